// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory arbiter slice.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_IFETCH = 2'd1,
    SRC_DATA   = 2'd2
  } src_t;

  localparam int unsigned MEM_READ_LATENCY = 2;
  localparam int unsigned DEF_ADDR_BITS    = 15;
  localparam int unsigned DEF_DATA_BITS    = 16;

endpackage

// File: rtl/mem_req_pipe.sv
// Two-stage request pipeline: stage 1 drives the memory, stage 2 tags the return.
module mem_req_pipe
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  src_t                 tag_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic [1:0]           wr_mask_i,
  output logic [ADDR_BITS-1:0] s1_addr_o,
  output logic                 s1_rd_o,
  output logic                 s1_wr_o,
  output logic [DATA_BITS-1:0] s1_wr_data_o,
  output logic [1:0]           s1_wr_mask_o,
  output src_t                 s2_tag_o,
  output logic [ADDR_BITS-1:0] s2_addr_o,
  output logic                 s2_rd_o
);

  src_t                 s1_tag_q, s2_tag_q;
  logic [ADDR_BITS-1:0] s1_addr_q, s2_addr_q;
  logic                 s1_rd_q, s1_wr_q, s2_rd_q;
  logic [DATA_BITS-1:0] s1_wr_data_q;
  logic [1:0]           s1_wr_mask_q;

  // Reset squashes both stages on the same edge, dropping anything in flight.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      s1_tag_q     <= SRC_NONE;
      s1_addr_q    <= '0;
      s1_rd_q      <= 1'b0;
      s1_wr_q      <= 1'b0;
      s1_wr_data_q <= '0;
      s1_wr_mask_q <= '0;
      s2_tag_q     <= SRC_NONE;
      s2_addr_q    <= '0;
      s2_rd_q      <= 1'b0;
    end else begin
      s1_tag_q     <= tag_i;
      s1_addr_q    <= addr_i;
      s1_rd_q      <= rd_i;
      s1_wr_q      <= wr_i;
      s1_wr_data_q <= wr_data_i;
      s1_wr_mask_q <= wr_mask_i;
      s2_tag_q     <= s1_tag_q;
      s2_addr_q    <= s1_addr_q;
      s2_rd_q      <= s1_rd_q;
    end
  end

  assign s1_addr_o    = s1_addr_q;
  assign s1_rd_o      = s1_rd_q;
  assign s1_wr_o      = s1_wr_q;
  assign s1_wr_data_o = s1_wr_data_q;
  assign s1_wr_mask_o = s1_wr_mask_q;
  assign s2_tag_o     = s2_tag_q;
  assign s2_addr_o    = s2_addr_q;
  assign s2_rd_o      = s2_rd_q;

endmodule

// File: rtl/cpu_memory_arbiter.sv
// Arbitrates instruction fetches and CPU data accesses onto one synchronous RAM
// with a fixed two-cycle return, bounding fetch starvation by STARVE_LIMIT.
module cpu_memory_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [ADDR_BITS-1:0] if_address,
  input  logic                 if_rd_req,
  output logic                 if_will_queue,
  output logic                 if_success,
  output logic [ADDR_BITS-1:0] if_requested_address,
  output logic [DATA_BITS-1:0] if_data,
  input  logic [ADDR_BITS-1:0] d_address,
  input  logic                 d_rd_req,
  input  logic                 d_wr_req,
  input  logic [DATA_BITS-1:0] d_wr_data,
  input  logic [1:0]           d_wr_mask,
  output logic                 d_grant,
  output logic                 d_rd_valid,
  output logic [DATA_BITS-1:0] d_rd_data,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_BITS-1:0] mem_wr_data,
  output logic [1:0]           mem_wr_mask,
  input  logic [DATA_BITS-1:0] mem_rd_data
);

  localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 grant_d, grant_f;
  src_t                 tag_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic                 rd_d, wr_d;
  logic [DATA_BITS-1:0] wr_data_d;
  logic [1:0]           wr_mask_d;
  src_t                 s2_tag;
  logic                 s2_rd;

  // Grants are held off during reset so nothing is accepted only to be squashed.
  always_comb begin
    grant_d   = RSTb && (d_rd_req || d_wr_req) && ((starve_q < LIMIT) || !if_rd_req);
    grant_f   = RSTb && if_rd_req && !grant_d;
    tag_d     = SRC_NONE;
    addr_d    = '0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    wr_data_d = '0;
    wr_mask_d = '0;
    if (grant_d) begin
      tag_d     = SRC_DATA;
      addr_d    = d_address;
      rd_d      = d_rd_req;
      wr_d      = d_wr_req;
      wr_data_d = d_wr_data;
      wr_mask_d = d_wr_mask;
    end else if (grant_f) begin
      tag_d  = SRC_IFETCH;
      addr_d = if_address;
      rd_d   = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_rd_req || grant_f) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_req_pipe #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_pipe (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .tag_i        (tag_d),
    .addr_i       (addr_d),
    .rd_i         (rd_d),
    .wr_i         (wr_d),
    .wr_data_i    (wr_data_d),
    .wr_mask_i    (wr_mask_d),
    .s1_addr_o    (mem_address),
    .s1_rd_o      (mem_rd),
    .s1_wr_o      (mem_wr),
    .s1_wr_data_o (mem_wr_data),
    .s1_wr_mask_o (mem_wr_mask),
    .s2_tag_o     (s2_tag),
    .s2_addr_o    (if_requested_address),
    .s2_rd_o      (s2_rd)
  );

  assign if_will_queue = grant_f;
  assign d_grant       = grant_d;
  assign if_success    = (s2_tag == SRC_IFETCH);
  assign if_data       = mem_rd_data;
  assign d_rd_valid    = (s2_tag == SRC_DATA) && s2_rd;
  assign d_rd_data     = mem_rd_data;

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Directed bench for cpu_memory_arbiter with a behavioural single-port RAM.
module tb_cpu_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [14:0] if_address = '0;
  logic        if_rd_req = 1'b0;
  logic        if_will_queue, if_success;
  logic [14:0] if_requested_address;
  logic [15:0] if_data;
  logic [14:0] d_address = '0;
  logic        d_rd_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] d_wr_data = '0;
  logic [1:0]  d_wr_mask = '0;
  logic        d_grant, d_rd_valid;
  logic [15:0] d_rd_data;
  logic [14:0] mem_address;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wr_data;
  logic [1:0]  mem_wr_mask;
  logic [15:0] mem_rd_data = '0;

  cpu_memory_arbiter #(
    .ADDR_BITS    (15),
    .DATA_BITS    (16),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK (CLK), .RSTb (RSTb),
    .if_address (if_address), .if_rd_req (if_rd_req), .if_will_queue (if_will_queue),
    .if_success (if_success), .if_requested_address (if_requested_address), .if_data (if_data),
    .d_address (d_address), .d_rd_req (d_rd_req), .d_wr_req (d_wr_req),
    .d_wr_data (d_wr_data), .d_wr_mask (d_wr_mask), .d_grant (d_grant),
    .d_rd_valid (d_rd_valid), .d_rd_data (d_rd_data),
    .mem_address (mem_address), .mem_rd (mem_rd), .mem_wr (mem_wr),
    .mem_wr_data (mem_wr_data), .mem_wr_mask (mem_wr_mask), .mem_rd_data (mem_rd_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] base_val(input logic [14:0] a);
    return (a == 15'h0030) ? 16'h1234 : ({1'b0, a} ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] m);
    return {m[1] ? n[15:8] : o[15:8], m[0] ? n[7:0] : o[7:0]};
  endfunction

  // Environment RAM: registered read, byte-masked write.
  bit          mem_v [0:32767];
  logic [15:0] mem_w [0:32767];
  always @(posedge CLK) begin
    if (mem_rd) mem_rd_data <= mem_v[mem_address] ? mem_w[mem_address] : base_val(mem_address);
    if (mem_wr) begin
      mem_w[mem_address] <= merge(mem_v[mem_address] ? mem_w[mem_address] : base_val(mem_address),
                                  mem_wr_data, mem_wr_mask);
      mem_v[mem_address] <= 1'b1;
    end
  end

  // Reference contents as seen in grant order.
  bit          ref_v [0:32767];
  logic [15:0] ref_w [0:32767];
  function automatic logic [15:0] ref_rd(input logic [14:0] a);
    return ref_v[a] ? ref_w[a] : base_val(a);
  endfunction

  typedef struct {
    bit rstb; bit ifr; logic [14:0] ifa;
    bit drd; bit dwr; logic [14:0] da; logic [15:0] wd; logic [1:0] wm;
    bit eq; bit eg;
  } vec_t;

  typedef enum int {K_NONE, K_IF, K_DRD, K_DWR} kind_e;
  typedef struct { kind_e k; logic [14:0] a; logic [15:0] d; logic [1:0] m; } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t e1, e2, enone;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic vec_t V(bit rstb, bit ifr, logic [14:0] ifa, bit drd, bit dwr,
                             logic [14:0] da, logic [15:0] wd, logic [1:0] wm, bit eq, bit eg);
    vec_t v;
    v.rstb = rstb; v.ifr = ifr; v.ifa = ifa; v.drd = drd; v.dwr = dwr;
    v.da = da; v.wd = wd; v.wm = wm; v.eq = eq; v.eg = eg;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t nx;
    @(negedge CLK);
    RSTb = v.rstb; if_rd_req = v.ifr; if_address = v.ifa;
    d_rd_req = v.drd; d_wr_req = v.dwr; d_address = v.da; d_wr_data = v.wd; d_wr_mask = v.wm;
    #1;
    chk("if_will_queue", if_will_queue, v.eq);
    chk("d_grant", d_grant, v.eg);
    chk("mem_rd", mem_rd, (e1.k == K_IF) || (e1.k == K_DRD));
    chk("mem_wr", mem_wr, e1.k == K_DWR);
    if (e1.k != K_NONE) chk("mem_address", mem_address, e1.a);
    if (e1.k == K_DWR) begin
      chk("mem_wr_data", mem_wr_data, e1.d);
      chk("mem_wr_mask", mem_wr_mask, e1.m);
    end
    chk("if_success", if_success, e2.k == K_IF);
    chk("d_rd_valid", d_rd_valid, e2.k == K_DRD);
    if (e2.k == K_IF) begin
      chk("if_requested_address", if_requested_address, e2.a);
      chk("if_data", if_data, e2.d);
    end
    if (e2.k == K_DRD) chk("d_rd_data", d_rd_data, e2.d);
    nx = enone;
    if (v.eg && v.dwr) begin
      nx.k = K_DWR; nx.a = v.da; nx.d = v.wd; nx.m = v.wm;
      ref_w[v.da] = merge(ref_rd(v.da), v.wd, v.wm);
      ref_v[v.da] = 1'b1;
    end else if (v.eg) begin
      nx.k = K_DRD; nx.a = v.da; nx.d = ref_rd(v.da);
    end else if (v.eq) begin
      nx.k = K_IF; nx.a = v.ifa; nx.d = ref_rd(v.ifa);
    end
    if (!v.rstb) begin
      e1 = enone; e2 = enone;
    end else begin
      e2 = e1; e1 = nx;
    end
  endtask

  vec_t tbl[$];
  vec_t idle;
  int   succ_cnt, dg_cnt, if_cnt;

  initial begin
    enone.k = K_NONE; enone.a = '0; enone.d = '0; enone.m = '0;
    e1 = enone; e2 = enone;
    idle = V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with requests asserted: nothing accepted, everything cleared.
    for (int i = 0; i < 3; i++) step(V(0, 1, 15'h0011, 1, 0, 15'h0022, 0, 0, 0, 0));
    chk("rst mem_address", mem_address, 0);
    chk("rst mem_wr_data", mem_wr_data, 0);
    chk("rst mem_wr_mask", mem_wr_mask, 0);
    chk("rst if_requested_address", if_requested_address, 0);

    for (int i = 0; i < 10; i++) step(idle);

    // Streaming fetch 0x0100..0x010F
    for (int i = 0; i < 16; i++) step(V(1, 1, 15'(32'h100 + i), 0, 0, 0, 0, 0, 1, 0));
    step(idle); step(idle);

    // Priority
    tbl.push_back(V(1, 1, 15'h0020, 1, 0, 15'h0040, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0020, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle); tbl.push_back(idle);
    // Masked write then fetch of the same word; full-low-byte write then data read
    tbl.push_back(V(1, 0, 0, 0, 1, 15'h0030, 16'hBEEF, 2'b10, 0, 1));
    tbl.push_back(V(1, 1, 15'h0030, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 0, 0, 0, 1, 15'h0031, 16'h5A5A, 2'b01, 0, 1));
    tbl.push_back(V(1, 0, 0, 1, 0, 15'h0031, 0, 0, 0, 1));
    tbl.push_back(idle); tbl.push_back(idle);
    // Mid-flight reset
    tbl.push_back(V(1, 1, 15'h0050, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 1, 15'h0051, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle); tbl.push_back(idle);
    tbl.push_back(V(1, 1, 15'h0052, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle); tbl.push_back(idle);
    // Dropping if_rd_req clears the starvation count
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0041, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0042, 0, 0, 0, 1));
    tbl.push_back(V(1, 0, 15'h0070, 1, 0, 15'h0043, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0044, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0045, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0046, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0047, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 15'h0070, 1, 0, 15'h0048, 0, 0, 1, 0));
    tbl.push_back(idle); tbl.push_back(idle);
    foreach (tbl[i]) step(tbl[i]);

    // Starvation: four data grants then one fetch, repeating
    succ_cnt = 0; dg_cnt = 0; if_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if ((k % 5) < 4) begin
        step(V(1, 1, 15'(32'h60 + if_cnt), 1, 0, 15'(32'h200 + dg_cnt), 0, 0, 0, 1));
        dg_cnt++;
      end else begin
        step(V(1, 1, 15'(32'h60 + if_cnt), 1, 0, 15'(32'h200 + dg_cnt), 0, 0, 1, 0));
        if_cnt++;
      end
      if (if_success) succ_cnt++;
    end
    step(idle); if (if_success) succ_cnt++;
    step(idle); if (if_success) succ_cnt++;
    chk("starve if_success count", succ_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
